// File: rtl/bcd_display_ctrl_if.sv
// Handshake and display bus of the BCD display controller.
// The master side (source/bench) drives load/bin; the slave side (controller) drives the rest.
interface bcd_display_ctrl_if;
  logic       load;
  logic [7:0] bin;
  logic       busy;
  logic       done;
  logic [9:0] bcd;
  logic [3:0] digit;
  logic [2:0] an;
  logic       blank;

  modport master (
    output load, bin,
    input  busy, done, bcd, digit, an, blank
  );

  modport slave (
    input  load, bin,
    output busy, done, bcd, digit, an, blank
  );
endinterface

// File: rtl/bcd_display_ctrl.sv
// Sequential double-dabble binary-to-BCD converter (one shift per clock) that holds the last
// result and scans its three digits onto a shared seven-segment bus with active-low anodes.
module bcd_display_ctrl #(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  bcd_display_ctrl_if.slave bus
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t     state, state_next;
  logic [7:0] sr, sr_next;
  logic [9:0] acc, acc_next, acc_adj;
  logic [2:0] cnt, cnt_next;
  logic [9:0] bcd_q, bcd_next;
  logic       done_q, done_next;

  logic [PW-1:0] pre, pre_next;
  logic [1:0]    idx, idx_next;
  logic [3:0]    digit_q, digit_next;
  logic [2:0]    an_q, an_next;
  logic          blank_q, blank_next;
  logic          hund_zero, tens_zero;

  // Add-3 correction before each shift; the hundreds pair never exceeds 2 for an 8-bit input.
  always_comb begin
    acc_adj = acc;
    if (acc[3:0] >= 4'd5) acc_adj[3:0] = acc[3:0] + 4'd3;
    if (acc[7:4] >= 4'd5) acc_adj[7:4] = acc[7:4] + 4'd3;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    sr_next    = sr;
    acc_next   = acc;
    cnt_next   = cnt;
    bcd_next   = bcd_q;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.load) begin
          sr_next    = bus.bin;
          acc_next   = '0;
          cnt_next   = '0;
          state_next = CONV;
        end
      end
      CONV: begin
        {acc_next, sr_next} = {acc_adj[8:0], sr, 1'b0};
        cnt_next            = cnt + 3'd1;
        if (cnt == 3'd7) begin
          state_next = IDLE;
          bcd_next   = acc_next;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Scan index steps once per prescaler wrap; the display registers load from the next-cycle
  // index and result so they change on the same edge as either.
  always_comb begin
    pre_next = (pre == PRE_MAX) ? '0 : pre + 1'b1;
    idx_next = idx;
    if (pre == PRE_MAX) idx_next = (idx == 2'd2) ? 2'd0 : idx + 2'd1;

    hund_zero = (bcd_next[9:8] == 2'd0);
    tens_zero = hund_zero && (bcd_next[7:4] == 4'd0);

    digit_next = bcd_next[3:0];
    an_next    = 3'b110;
    blank_next = 1'b0;
    case (idx_next)
      2'd1: begin
        digit_next = bcd_next[7:4];
        an_next    = 3'b101;
        blank_next = BLANK_LZ && tens_zero;
      end
      2'd2: begin
        digit_next = {2'b00, bcd_next[9:8]};
        an_next    = 3'b011;
        blank_next = BLANK_LZ && hund_zero;
      end
      default: ;
    endcase
    if (blank_next) an_next = 3'b111;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sr      <= '0;
      acc     <= '0;
      cnt     <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
      pre     <= '0;
      idx     <= '0;
      digit_q <= '0;
      an_q    <= 3'b110;
      blank_q <= 1'b0;
    end else begin
      state   <= state_next;
      sr      <= sr_next;
      acc     <= acc_next;
      cnt     <= cnt_next;
      bcd_q   <= bcd_next;
      done_q  <= done_next;
      pre     <= pre_next;
      idx     <= idx_next;
      digit_q <= digit_next;
      an_q    <= an_next;
      blank_q <= blank_next;
    end
  end

  assign bus.busy  = (state == CONV);
  assign bus.done  = done_q;
  assign bus.bcd   = bcd_q;
  assign bus.digit = digit_q;
  assign bus.an    = an_q;
  assign bus.blank = blank_q;

endmodule

// File: doc/bcd_display_ctrl.md
Name: bcd_display_ctrl

Overview:
- Multi-cycle controller that converts an 8-bit binary value to 3-digit BCD using shift-and-add-3 (double dabble), one shift per clock, instead of the combinational unrolled form.
- Holds the last completed result and time-multiplexes its three digits onto one shared seven-segment digit bus, with active-low anode enables.
- Sits between the switch/datapath source and a single external sevenSeg decoder instance that is driven from the digit output.

Parameters:
- SCAN_DIV, 50000, clock cycles each digit stays enabled; legal range 2 or more.
- BLANK_LZ, 1, 1 = blank leading-zero digits; 0 = always light all three digits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  request to start a conversion of bin; sampled only in IDLE.
- bin  in  8  unsigned binary value; captured on an accepted load.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when bcd is updated.
- bcd  out  10  latched result; [9:8] hundreds, [7:4] tens, [3:0] ones.
- digit  out  4  BCD nibble for the currently scanned digit; feeds sevenSeg.
- an  out  3  one-hot active-low anode select; bit0 = ones, bit1 = tens, bit2 = hundreds.
- blank  out  1  high when the current digit is suppressed.

Behaviour:
- Reset values: busy=0, done=0, bcd=0, digit=0, an=3'b110, blank=0, FSM=IDLE, prescaler=0, scan index=0, internal shift/count registers=0.
- Reset has priority over all other inputs. Reset mid-conversion aborts the conversion; bcd returns to 0 and no done pulse is produced.
- FSM states: IDLE, CONV.
  - IDLE: when load=1 at an edge, capture bin, clear the 10-bit accumulator, set the bit counter to 0, and go to CONV. busy=1 from that edge.
  - CONV, every cycle:
    - Add 3 to each of the ones and tens accumulator nibbles that is 5 or more.
    - Shift {accumulator, shift reg} left by 1.
    - Increment the bit counter.
  - After the 8th shift, return to IDLE on the same edge: bcd takes the final accumulator, busy=0, done=1 for exactly one cycle.
- Latency: load sampled at edge k gives busy high for cycles k+1 through k+8. At edge k+8, bcd is valid and done rises; done falls at edge k+9.
- load while busy=1 is ignored (not queued). load in the cycle where done=1 is accepted, since the FSM is already in IDLE.
- bcd changes only at done. The display never shows intermediate accumulator values.
- Range: the result is at most 255, so the hundreds digit is at most 2. No overflow is possible.
- Scan prescaler:
  - Free-running counter 0..SCAN_DIV-1, independent of conversion state.
  - On wrap, the scan index advances 0→1→2→0.
  - digit, an and blank are registered and change on the edge the index changes.
- Digit select:
  - idx0: digit=bcd[3:0], an=3'b110.
  - idx1: digit=bcd[7:4], an=3'b101.
  - idx2: digit={2'b00,bcd[9:8]}, an=3'b011.
- Blanking, when BLANK_LZ=1:
  - Hundreds digit is blanked if bcd[9:8]==0.
  - Tens digit is blanked if bcd[9:8]==0 and bcd[7:4]==0.
  - Ones digit is never blanked.
  - A blanked digit forces an=3'b111 and blank=1; digit is still driven with its nibble.
- BLANK_LZ=0: blank is always 0.

Test Plan:
- Reset, then load bin=8'd255 for one cycle → busy high 8 cycles; done pulse at cycle 9; bcd=10'h255 (10_0101_0101); busy=0 on that same edge.
- Load bin=8'd0 with SCAN_DIV=4, BLANK_LZ=1 → bcd=0. Scan an sequence over 12 cycles: 110 (digit 0), then 111 with blank=1, then 111 with blank=1. Repeats every 12 cycles.
- Load bin=8'd7, then bin=8'd60, then bin=8'd100 → bcd values 0x007, 0x060, 0x100. Tens lit only for 60 and 100; hundreds lit only for 100; tens of 100 shown as 0 and not blanked.
- Load bin=8'd99, then pulse load with bin=8'd200 at busy cycle 3 → second load ignored; bcd=0x099, single done pulse. Re-issue load in the done cycle → accepted; bcd=0x200 nine cycles later.
- Assert rst at busy cycle 5 of a bin=8'd128 conversion → next cycle busy=0, bcd=0, an=3'b110; no done pulse. A following load of 128 gives bcd=0x128.
- BLANK_LZ=0, bin=8'd5, SCAN_DIV=2 → an cycles 110 / 101 / 011 every 2 clocks; digits 5, 0, 0; blank always 0.
